// File: rtl/ping_ctrl.sv
// Ping controller: fires a transmit burst on request, waits for the echo
// (or gives up after TIMEOUT counts) and reports the latency.
// Optional retry on timeout is built when PING_RETRY_EN is defined.
module ping_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned BLANK     = 8,
    parameter int unsigned TIMEOUT   = 48000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stb,
    input  logic             rx_stb,
    output logic             tx_en,
    output logic             busy,
    output logic             res_stb,
    output logic [CNT_W-1:0] res_lat,
    output logic             res_timeout,
    output logic [1:0]       res_tries
);

    localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] RX_OPEN  = CNT_W'(BURST_LEN + BLANK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    // Elaboration-time parameter sanity checks
    if (TIMEOUT <= BURST_LEN + BLANK) begin : g_bad_timeout
        $error("ping_ctrl: TIMEOUT must exceed BURST_LEN+BLANK");
    end
    if (MAX_RETRY > 3) begin : g_bad_retry
        $error("ping_ctrl: MAX_RETRY must fit in the 2-bit tries field");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TX     = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tries_q, tries_d;
    logic             tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
    logic             res_stb_q, res_stb_d;
    logic [CNT_W-1:0] res_lat_q, res_lat_d;
    logic             res_timeout_q, res_timeout_d;
    logic [1:0]       res_tries_q, res_tries_d;
    logic             echo_ok;

    // Echo is only accepted while listening and past the blanking window
    assign echo_ok = (state_q == ST_LISTEN) && rx_stb && (cnt_q >= RX_OPEN);

    // Next-state, counter and result capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tries_d       = tries_q;
        res_stb_d     = 1'b0;
        res_lat_d     = res_lat_q;
        res_timeout_d = res_timeout_q;
        res_tries_d   = res_tries_q;

        case (state_q)
            ST_IDLE: begin
                if (start_stb) begin
                    state_d = ST_TX;
                    cnt_d   = '0;
                    tries_d = 2'd0;
                end
            end
            ST_TX: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_TX) begin
                    state_d = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                if (echo_ok) begin
                    state_d       = ST_DONE;
                    res_stb_d     = 1'b1;
                    res_lat_d     = cnt_q;
                    res_timeout_d = 1'b0;
                    res_tries_d   = tries_q;
                end else if (cnt_q == LAST_CNT) begin
`ifdef PING_RETRY_EN
                    if (tries_q < 2'(MAX_RETRY)) begin
                        state_d = ST_TX;
                        cnt_d   = '0;
                        tries_d = tries_q + 2'd1;
                    end else begin
                        state_d       = ST_DONE;
                        res_stb_d     = 1'b1;
                        res_lat_d     = LAST_CNT;
                        res_timeout_d = 1'b1;
                        res_tries_d   = tries_q;
                    end
`else
                    state_d       = ST_DONE;
                    res_stb_d     = 1'b1;
                    res_lat_d     = LAST_CNT;
                    res_timeout_d = 1'b1;
                    res_tries_d   = 2'd0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_en_d = (state_d == ST_TX);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tries_q       <= 2'd0;
            tx_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            res_stb_q     <= 1'b0;
            res_lat_q     <= '0;
            res_timeout_q <= 1'b0;
            res_tries_q   <= 2'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tries_q       <= tries_d;
            tx_en_q       <= tx_en_d;
            busy_q        <= busy_d;
            res_stb_q     <= res_stb_d;
            res_lat_q     <= res_lat_d;
            res_timeout_q <= res_timeout_d;
            res_tries_q   <= res_tries_d;
        end
    end

    assign tx_en       = tx_en_q;
    assign busy        = busy_q;
    assign res_stb     = res_stb_q;
    assign res_lat     = res_lat_q;
    assign res_timeout = res_timeout_q;
    assign res_tries   = res_tries_q;

endmodule

// File: tb/tb_ping_ctrl.sv
// Self-checking bench for ping_ctrl: directed scenarios with hand-computed
// results plus randomized traffic checked every cycle against an
// elapsed-time model of one ping in flight.
module tb_ping_ctrl;

    localparam int CNT_W     = 8;
    localparam int BURST_LEN = 4;
    localparam int BLANK     = 2;
    localparam int TIMEOUT   = 20;
    localparam int MAX_RETRY = 2;
`ifdef PING_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_stb = 1'b0;
    logic             rx_stb = 1'b0;
    logic             tx_en;
    logic             busy;
    logic             res_stb;
    logic [CNT_W-1:0] res_lat;
    logic             res_timeout;
    logic [1:0]       res_tries;

    ping_ctrl #(
        .CNT_W(CNT_W), .BURST_LEN(BURST_LEN), .BLANK(BLANK),
        .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .start_stb(start_stb), .rx_stb(rx_stb),
        .tx_en(tx_en), .busy(busy), .res_stb(res_stb), .res_lat(res_lat),
        .res_timeout(res_timeout), .res_tries(res_tries)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a ping is "active" with elapsed count m_e in its current attempt
    bit m_active = 0, m_done = 0;
    int m_e = 0, m_try = 0, m_lat = 0, m_to = 0, m_tries = 0;

    task automatic report(input int lat, input int to);
        m_lat = lat; m_to = to; m_tries = m_try; m_done = 1;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_active = 0; m_done = 0; m_e = 0; m_try = 0;
            m_lat = 0; m_to = 0; m_tries = 0;
        end else if (m_done) begin
            m_done = 0; m_active = 0;
        end else if (!m_active) begin
            if (start_stb) begin m_active = 1; m_e = 0; m_try = 0; end
        end else if (m_e >= BURST_LEN + BLANK && rx_stb) begin
            report(m_e, 0);
        end else if (m_e == TIMEOUT - 1) begin
            if (RETRY && m_try < MAX_RETRY) begin m_try++; m_e = 0; end
            else report(TIMEOUT - 1, 1);
        end else begin
            m_e++;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_en", int'(tx_en), int'(m_active && !m_done && m_e < BURST_LEN));
            check("busy", int'(busy), int'(m_active));
            check("res_stb", int'(res_stb), int'(m_done));
            check("res_lat", int'(res_lat), m_lat);
            check("res_timeout", int'(res_timeout), m_to);
            check("res_tries", int'(res_tries), m_tries);
        end
    end

    // Apply inputs for one cycle, return #1 after the next rising edge
    task automatic step(input bit s, input bit r, input bit rn);
        start_stb = s; rx_stb = r; rst = rn;
        @(posedge clk);
        #1;
    endtask

    int n_res, res_cyc, r_lat, r_to, r_tries, tx_hi, tx_rise, tx_first, tx_last;
    int busy_hist [0:79];

    // One ping starting at cycle 0; rx at given first-attempt counter values, extra starts at given cycles
    task automatic run_ping(input int rx_a, input int rx_b, input int st_a, input int st_b);
        bit prev_tx;
        n_res = 0; res_cyc = -1; r_lat = -1; r_to = -1; r_tries = -1;
        tx_hi = 0; tx_rise = 0; tx_first = -1; tx_last = -1; prev_tx = 0;
        step(1, 0, 1);
        for (int i = 1; i < 80; i++) begin
            if (tx_en) begin
                tx_hi++;
                if (!prev_tx) tx_rise++;
                if (tx_first < 0) tx_first = i;
                tx_last = i;
            end
            prev_tx = tx_en;
            busy_hist[i] = int'(busy);
            if (res_stb) begin
                n_res++; res_cyc = i; r_lat = int'(res_lat);
                r_to = int'(res_timeout); r_tries = int'(res_tries);
            end
            step(i == st_a || i == st_b, (i - 1) == rx_a || (i - 1) == rx_b, 1);
        end
        step(0, 0, 1);
        step(0, 0, 1);
    endtask

    initial begin
        step(0, 0, 0);
        step(1, 0, 0);
        chk_en = 1'b1;
        check("reset_tx_en", int'(tx_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_res_lat", int'(res_lat), 0);
        check("reset_res_tries", int'(res_tries), 0);
        step(0, 0, 1);

        // Echo at cycle 10
        run_ping(9, -1, -1, -1);
        check("echo_res_cycle", res_cyc, 11);
        check("echo_res_lat", r_lat, 9);
        check("echo_res_timeout", r_to, 0);
        check("echo_tx_first", tx_first, 1);
        check("echo_tx_last", tx_last, 4);
        check("echo_res_count", n_res, 1);

        // Echoes inside burst and blanking are ignored -> timeout
        run_ping(3, 5, -1, -1);
        check("blank_res_count", n_res, 1);
        check("blank_res_lat", r_lat, 19);
        check("blank_res_timeout", r_to, 1);
        check("blank_tries", r_tries, RETRY ? 2 : 0);
        check("blank_bursts", tx_rise, RETRY ? 3 : 1);
        check("blank_tx_cycles", tx_hi, RETRY ? 12 : 4);
        check("blank_res_cycle", res_cyc, RETRY ? 61 : 21);

        // Echo exactly at the last count beats the timeout
        run_ping(19, -1, -1, -1);
        check("edge_res_lat", r_lat, 19);
        check("edge_res_timeout", r_to, 0);
        check("edge_res_cycle", res_cyc, 21);

        // Starts while busy are dropped
        run_ping(9, -1, 2, 8);
        check("busy_start_bursts", tx_rise, 1);
        check("busy_start_res", n_res, 1);

        // Start in DONE ignored, start one cycle later accepted
        run_ping(9, -1, 11, 12);
        check("done_start_idle", busy_hist[12], 0);
        check("done_start_accept", busy_hist[13], 1);
        check("done_start_bursts", tx_rise, 2);
        check("done_start_res", n_res, 2);

        // Reset at counter 2 with a concurrent start
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        check("rst_mid_tx_en", int'(tx_en), 0);
        check("rst_mid_busy", int'(busy), 0);
        n_res = 0; tx_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_stb) n_res++;
            if (tx_en) tx_hi++;
            step(0, 0, 1);
        end
        check("rst_mid_no_res", n_res, 0);
        check("rst_mid_no_tx", tx_hi, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 299) != 0);
        end

        step(0, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
